forwarding_br_sb: RTL
=====================

Name: forwarding_br_sb

Overview:
ID-stage branch-operand forwarding unit with an integrated scoreboard for long-latency writers (divider, FPU). For each branch source it selects register file, MEM-stage or WB-stage data, and asserts a stall while a source is still being produced. Replaces the WB-only, purely combinational branch forwarder. Optionally tracks a separate float register file, where f0 is a real register.

Parameters:
FLOAT, 0, 1 = track int and float register files; 0 = int only, all float inputs ignored
NUM_SRC, 2, number of branch source operands checked
LAT_W, 3, width of the latency counter; maximum tracked latency is 2^LAT_W-1 cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rs_id  in  5*NUM_SRC  source register indices; source i is bits [5i+4:5i]
rs_float  in  NUM_SRC  source i reads the float file
mem_valid  in  1  MEM stage writes a register
mem_rd  in  5  MEM destination
mem_float  in  1  MEM destination is in the float file
mem_is_load  in  1  MEM result is not yet available (load)
wb_valid  in  1  WB stage writes a register
wb_rd  in  5  WB destination
wb_float  in  1  WB destination is in the float file
iss_valid  in  1  long-latency op issued this cycle
iss_rd  in  5  its destination
iss_float  in  1  its destination is in the float file
iss_lat  in  LAT_W  cycles until its result reaches WB
fw_sel  out  2*NUM_SRC  per source: 00 regfile, 01 MEM, 10 WB
stall  out  1  hold ID this cycle
stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at a clk edge): all busy bits, latency counters and stall_cnt are cleared to 0. Outputs are combinational from state, so they read fw_sel=0 and stall=0 unless inputs match.
- File match: an entry matches source i when rd == rs_i and (FLOAT=0 or file bit == rs_float[i]).
- Zero register: integer rd/rs 0 never matches. When FLOAT=1, float f0 matches normally.
- fw_sel[i]: 01 if mem_valid and mem matches and not mem_is_load; else 10 if wb_valid and wb matches; else 00. MEM has priority over WB because it is younger.
- Scoreboard: one busy bit plus one LAT_W counter per register per file (32 entries when FLOAT=0, 64 when FLOAT=1). Integer entry 0 is never set.
- Issue, at the clk edge when iss_valid and iss_lat != 0: set busy and load counter = iss_lat. A re-issue to a busy entry (WAW) overwrites the counter. iss_lat = 0 is ignored.
- Countdown, each cycle for every busy entry not being issued: counter decrements by 1. When the counter goes from 1 to 0, busy clears in that same edge.
- Issue and expiry of the same entry in the same cycle: issue wins, busy stays 1 and the counter reloads.
- stall = OR over sources of:
  - source matches a busy entry, except when WB also matches it this cycle (WB forwards); or
  - mem_valid, mem matches, and mem_is_load.
- Stall is combinational, with no added latency. fw_sel is still driven during stall.
- stall_cnt increments each cycle stall=1 and saturates at 16'hFFFF.
- rst asserted mid-countdown clears all entries on that edge. Pending issues are dropped.
- Issue inputs are sampled even when stall=1.

Test Plan:
1. rs_id={5'd3,5'd2}, mem_valid=1, mem_rd=2, wb_valid=1, wb_rd=2 -> fw_sel[1:0]=01 (MEM wins), fw_sel[3:2]=00, stall=0.
2. mem_rd=5, mem_is_load=1, rs0=5 -> stall=1, stall_cnt increments by 1. Next cycle wb_rd=5, mem_valid=0 -> fw_sel[1:0]=10, stall=0.
3. iss_valid, iss_rd=7, iss_lat=3, then rs0=7 held -> stall=1 for exactly 3 cycles after issue, 0 on the 4th. On the cycle wb_rd=7 coincides with busy, stall=0 and fw_sel=10.
4. FLOAT=1: wb_rd=0, wb_float=1, rs0=0, rs_float[0]=1 -> fw_sel=10. Same with wb_float=0 (integer x0) -> fw_sel=00. wb_float=1 with rs_float[0]=0, rd=4=rs0 -> no match.
5. iss_rd=9, lat=5; two cycles later re-issue rd=9, lat=2 -> busy clears 2 cycles after the second issue. iss_lat=0 -> no stall ever.
6. Force stall for 70000 cycles -> stall_cnt=16'hFFFF. rst mid-countdown of rd=12 -> next cycle stall=0 and stall_cnt=0.

Source files
------------

// File: rtl/forwarding_br_sb.sv
// forwarding_br_sb
//   ID-stage branch-operand forwarding unit with a scoreboard for
//   long-latency writers (divider, FPU). Each branch source picks regfile,
//   MEM or WB data; stall is raised while a source is still being produced.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   rs_id, rs_float       branch sources (5 bits each) and their file bit
//   mem_*                 MEM-stage writer (valid, rd, float, is_load)
//   wb_*                  WB-stage writer (valid, rd, float)
//   iss_*                 long-latency issue (valid, rd, float, lat)
//   fw_sel                per source: 00 regfile, 01 MEM, 10 WB
//   stall                 hold ID this cycle (combinational)
//   stall_cnt             saturating count of stall cycles
module forwarding_br_sb #(
    parameter int FLOAT   = 0,
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5*NUM_SRC-1:0]   rs_id,
    input  logic [NUM_SRC-1:0]     rs_float,
    input  logic                   mem_valid,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_float,
    input  logic                   mem_is_load,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_float,
    input  logic                   iss_valid,
    input  logic [4:0]             iss_rd,
    input  logic                   iss_float,
    input  logic [LAT_W-1:0]       iss_lat,
    output logic [2*NUM_SRC-1:0]   fw_sel,
    output logic                   stall,
    output logic [15:0]            stall_cnt
);

    localparam int NE = (FLOAT != 0) ? 64 : 32;
    localparam int IW = (FLOAT != 0) ? 6 : 5;

    logic [NE-1:0]    busy_q, busy_d;
    logic [LAT_W-1:0] cnt_q [NE];
    logic [LAT_W-1:0] cnt_d [NE];
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic             iss_ok;
    logic [IW-1:0]    iss_idx;

    // Scoreboard slot: float registers live in the upper half when FLOAT=1;
    // with FLOAT=0 the file bit is truncated away.
    function automatic logic [IW-1:0] ent(input logic [4:0] r, input logic fl);
        logic [5:0] full;
        full = {fl & (FLOAT != 0), r};
        return IW'(full);
    endfunction

    // Integer x0 never matches; float f0 is a real register.
    function automatic logic is_int_zero(input logic [4:0] r, input logic fl);
        return (r == 5'd0) && ((FLOAT == 0) || !fl);
    endfunction

    function automatic logic hit(input logic [4:0] rd, input logic fl,
                                 input logic [4:0] rs, input logic rs_fl);
        logic same_file;
        same_file = (FLOAT == 0) || (fl == rs_fl);
        return (rd == rs) && same_file && !is_int_zero(rd, fl);
    endfunction

    assign iss_ok  = iss_valid && (iss_lat != '0) && !is_int_zero(iss_rd, iss_float);
    assign iss_idx = ent(iss_rd, iss_float);

    always_comb begin
        busy_d = busy_q;
        for (int e = 0; e < NE; e++) begin
            cnt_d[e] = cnt_q[e];
            if (busy_q[e]) begin
                cnt_d[e] = cnt_q[e] - LAT_W'(1);
                if (cnt_q[e] == LAT_W'(1)) begin
                    busy_d[e] = 1'b0;
                end
            end
            // A new issue overrides both countdown and expiry.
            if (iss_ok && (IW'(e) == iss_idx)) begin
                busy_d[e] = 1'b1;
                cnt_d[e]  = iss_lat;
            end
        end
    end

    always_comb begin
        logic [4:0] rs;
        logic       rsf;
        logic       mem_hit;
        logic       wb_hit;
        fw_sel = '0;
        stall  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs      = rs_id[5*i +: 5];
            rsf     = rs_float[i];
            mem_hit = mem_valid && hit(mem_rd, mem_float, rs, rsf);
            wb_hit  = wb_valid && hit(wb_rd, wb_float, rs, rsf);
            // A load in MEM has no data yet, so it falls through to WB.
            if (mem_hit && !mem_is_load) begin
                fw_sel[2*i +: 2] = 2'b01;
            end else if (wb_hit) begin
                fw_sel[2*i +: 2] = 2'b10;
            end
            // Integer slot 0 is never set, so x0 cannot stall here.
            if (busy_q[ent(rs, rsf)] && !wb_hit) begin
                stall = 1'b1;
            end
            if (mem_hit && mem_is_load) begin
                stall = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
            for (int e = 0; e < NE; e++) begin
                cnt_q[e] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            for (int e = 0; e < NE; e++) begin
                cnt_q[e] <= cnt_d[e];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
